// File: rtl/disk_req_arbiter.sv
// Shares the two virtual-disk block channels between floppy track loads (drive 0)
// and HDD single-block jobs (drive 1), one block outstanding at a time.
module disk_req_arbiter #(
  parameter int FDD_SECTORS = 13
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [5:0]  fdd_track,
  input  logic        fdd_img_valid,
  input  logic        fdd_remount,
  input  logic        hdd_rd_req,
  input  logic        hdd_wr_req,
  input  logic [31:0] hdd_lba,
  input  logic [1:0]  sd_ack,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  output logic [31:0] sd_lba0,
  output logic [31:0] sd_lba1,
  output logic [3:0]  fdd_sec,
  output logic        cpu_wait,
  output logic [1:0]  busy
);

  typedef enum logic [2:0] {IDLE, DRAIN, FDD_REQ, FDD_XFER, HDD_REQ, HDD_XFER} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cur_track, cur_track_nxt;
  logic [3:0]  fdd_blk, fdd_blk_nxt;
  logic        fdd_pend, fdd_pend_nxt;
  logic        restart, restart_nxt;
  logic        rd_pend, rd_pend_nxt;
  logic        wr_pend, wr_pend_nxt;
  logic        hdd_op_wr, hdd_op_wr_nxt;
  logic        last_hdd, last_hdd_nxt;
  logic [31:0] hdd_lba_r, hdd_lba_r_nxt;
  logic [1:0]  sd_rd_nxt, sd_wr_nxt;
  logic [1:0]  sd_ack_p1;
  logic [1:0]  ack_rise, ack_fall;
  logic        fdd_trig, fdd_inflight, fdd_act_nxt, hdd_act_nxt;

  function automatic logic [31:0] fdd_lba(input logic [5:0] trk, input logic [3:0] blk);
    logic [9:0] lba;
    lba = 10'(FDD_SECTORS) * {4'd0, trk} + {6'd0, blk};
    return {22'd0, lba};
  endfunction

  assign ack_rise     = sd_ack & ~sd_ack_p1;
  assign ack_fall     = ~sd_ack & sd_ack_p1;
  assign fdd_trig     = (fdd_track != cur_track) || fdd_remount;
  // A restart only matters when an FDD block is still outstanding after this cycle.
  assign fdd_inflight = (state == FDD_REQ) || ((state == FDD_XFER) && !ack_fall[0]);

  always_comb begin
    state_nxt     = state;
    cur_track_nxt = cur_track;
    fdd_blk_nxt   = fdd_blk;
    fdd_pend_nxt  = fdd_pend;
    restart_nxt   = restart;
    rd_pend_nxt   = rd_pend;
    wr_pend_nxt   = wr_pend;
    hdd_op_wr_nxt = hdd_op_wr;
    last_hdd_nxt  = last_hdd;
    hdd_lba_r_nxt = hdd_lba_r;
    sd_rd_nxt     = sd_rd;
    sd_wr_nxt     = sd_wr;

    case (state)
      DRAIN: if (sd_ack == 2'b00) state_nxt = IDLE;
      IDLE: begin
        if ((rd_pend || wr_pend) && (!fdd_pend || !last_hdd)) begin
          state_nxt     = HDD_REQ;
          last_hdd_nxt  = 1'b1;
          hdd_op_wr_nxt = wr_pend;
          sd_wr_nxt[1]  = wr_pend;
          sd_rd_nxt[1]  = !wr_pend;
        end else if (fdd_pend) begin
          state_nxt    = FDD_REQ;
          last_hdd_nxt = 1'b0;
          sd_rd_nxt[0] = 1'b1;
        end
      end
      FDD_REQ: if (ack_rise[0]) begin
        sd_rd_nxt[0] = 1'b0;
        state_nxt    = FDD_XFER;
      end
      FDD_XFER: if (ack_fall[0]) begin
        state_nxt = IDLE;
        if (restart) restart_nxt = 1'b0;
        else if (fdd_blk == 4'(FDD_SECTORS - 1)) fdd_pend_nxt = 1'b0;
        else fdd_blk_nxt = fdd_blk + 4'd1;
      end
      HDD_REQ: if (ack_rise[1]) begin
        sd_rd_nxt[1] = 1'b0;
        sd_wr_nxt[1] = 1'b0;
        state_nxt    = HDD_XFER;
      end
      HDD_XFER: if (ack_fall[1]) begin
        state_nxt = IDLE;
        if (hdd_op_wr) wr_pend_nxt = 1'b0;
        else rd_pend_nxt = 1'b0;
      end
      default: state_nxt = DRAIN;
    endcase

    if (fdd_trig) begin
      cur_track_nxt = fdd_track;
      if (fdd_img_valid) begin
        fdd_pend_nxt = 1'b1;
        fdd_blk_nxt  = 4'd0;
        restart_nxt  = fdd_inflight;
      end
    end

    if (hdd_wr_req) wr_pend_nxt = 1'b1;
    if (hdd_rd_req) rd_pend_nxt = 1'b1;
    if (hdd_wr_req || hdd_rd_req) hdd_lba_r_nxt = hdd_lba;
  end

  assign fdd_act_nxt = (state_nxt == FDD_REQ) || (state_nxt == FDD_XFER);
  assign hdd_act_nxt = (state_nxt == HDD_REQ) || (state_nxt == HDD_XFER);

  // p1: registered ack copy, control state and all outputs
  always_ff @(posedge clk_sys) begin
    sd_ack_p1 <= sd_ack;
    hdd_lba_r <= hdd_lba_r_nxt;
    if (!reset_n) begin
      state     <= DRAIN;
      cur_track <= 6'd0;
      fdd_blk   <= 4'd0;
      fdd_pend  <= 1'b0;
      restart   <= 1'b0;
      rd_pend   <= 1'b0;
      wr_pend   <= 1'b0;
      hdd_op_wr <= 1'b0;
      last_hdd  <= 1'b0;
      sd_rd     <= 2'b00;
      sd_wr     <= 2'b00;
      sd_lba0   <= 32'd0;
      sd_lba1   <= 32'd0;
      fdd_sec   <= 4'd0;
      cpu_wait  <= 1'b0;
      busy      <= 2'b00;
    end else begin
      state     <= state_nxt;
      cur_track <= cur_track_nxt;
      fdd_blk   <= fdd_blk_nxt;
      fdd_pend  <= fdd_pend_nxt;
      restart   <= restart_nxt;
      rd_pend   <= rd_pend_nxt;
      wr_pend   <= wr_pend_nxt;
      hdd_op_wr <= hdd_op_wr_nxt;
      last_hdd  <= last_hdd_nxt;
      sd_rd     <= sd_rd_nxt;
      sd_wr     <= sd_wr_nxt;
      if ((state != FDD_REQ) && (state != FDD_XFER)) begin
        sd_lba0 <= fdd_lba(cur_track_nxt, fdd_blk_nxt);
        fdd_sec <= fdd_blk_nxt;
      end
      if ((state != HDD_REQ) && (state != HDD_XFER)) sd_lba1 <= hdd_lba_r_nxt;
      cpu_wait <= fdd_pend_nxt | rd_pend_nxt | wr_pend_nxt |
                  ((state_nxt != IDLE) && (state_nxt != DRAIN));
      busy     <= {rd_pend_nxt | wr_pend_nxt | hdd_act_nxt, fdd_pend_nxt | fdd_act_nxt};
    end
  end

endmodule
